lzw_code_sink: RTL and testbench

Capture-and-replay buffer at the output end of the LZW compressor. It accepts the encoder's code stream over a valid/eof interface and stores each code in on-chip RAM. Once end-of-file arrives it becomes a source and replays the stored codes using the same chip-select / show-ahead valid / eof protocol as the input file ROM. The replay side is what a downstream decoder or testbench checker reads from.

---
 rtl/lzw_code_sink.sv | 82 ++++++++
 tb/tb_lzw_code_sink.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lzw_code_sink.sv
// Capture-and-replay buffer for the LZW code stream: fills RAM until eof, then replays the
// stored codes with a chip-select / show-ahead valid / eof read protocol.
module lzw_code_sink #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_eof,
    output logic                  in_ready,
    input  logic                  rd_cs,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_eof,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    typedef enum logic [1:0] {StFill, StDrain, StEnd} state_e;

    localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CntOne    = (ADDR_WIDTH + 1)'(1);

    state_e                state;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  write_en;

    assign in_ready = (state == StFill) && (count < FullCount);
    assign write_en = rst_n && in_valid && in_ready;
    assign rd_valid = (state == StDrain) && (rd_ptr < count);
    // Only slots below count are ever shown, so the unreset RAM never leaks stale data.
    assign rd_data  = rd_valid ? mem[rd_ptr[ADDR_WIDTH-1:0]] : '0;
    assign rd_eof   = (state == StEnd);

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[count[ADDR_WIDTH-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StFill;
            count    <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                StFill: begin
                    if (write_en) begin
                        count <= count + CntOne;
                    end
                    if (in_valid && !in_ready) begin
                        overflow <= 1'b1;
                    end
                    if (in_eof) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    // One idle DRAIN cycle after the last read before eof is raised.
                    if (rd_ptr == count) begin
                        state <= StEnd;
                    end else if (rd_cs && rd_valid) begin
                        rd_ptr <= rd_ptr + CntOne;
                    end
                end
                StEnd: begin
                    state <= StEnd;
                end
                default: begin
                    state <= StFill;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzw_code_sink.sv
// Scoreboard bench for lzw_code_sink: writes push expected codes, a negedge monitor pops
// and compares them on every accepted read.
module tb_lzw_code_sink;

    localparam int AW = 7;
    localparam int DW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_eof = 1'b0;
    logic          in_ready;
    logic          rd_cs = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_eof;
    logic [AW:0]   count;
    logic          overflow;

    int            n_tests = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];
    int            codes1[11] = '{65, 66, 66, 65, 256, 258, 257, 65, 66, 66, 65};

    lzw_code_sink #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (128)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_eof  (in_eof),
        .in_ready(in_ready),
        .rd_cs   (rd_cs),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .rd_eof  (rd_eof),
        .count   (count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every read the DUT will accept at the next edge must match the queue head.
    always @(negedge clk) begin
        logic [DW-1:0] exp_code;
        if (rst_n && rd_cs && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL replay_extra: got %0d, required no code", rd_data);
            end else begin
                exp_code = exp_q.pop_front();
                check("replay_data", 32'(rd_data), 32'(exp_code));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted and checked between edges to prove it is asynchronous.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_eof   = 1'b0;
        rd_cs    = 1'b0;
        #1;
        check({tag, "_rst_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_rst_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rst_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_rst_rd_eof"}, 32'(rd_eof), 32'd0);
        check({tag, "_rst_count"}, 32'(count), 32'd0);
        check({tag, "_rst_overflow"}, 32'(overflow), 32'd0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic write_code(input int c);
        in_valid = 1'b1;
        in_data  = DW'(c);
        exp_q.push_back(DW'(c));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_eof();
        in_valid = 1'b0;
        in_eof   = 1'b1;
        tick();
        in_eof = 1'b0;
    endtask

    // Holds rd_cs high until rd_valid drops; expects n codes on n consecutive cycles.
    task automatic replay_all(input int n, input string tag);
        int cyc = 0;
        rd_cs = 1'b1;
        while (rd_valid && cyc < 300) begin
            tick();
            cyc++;
        end
        check({tag, "_read_cycles"}, 32'(cyc), 32'(n));
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_eof_gap"}, 32'(rd_eof), 32'd0);
        rd_cs = 1'b0;
        tick();
        check({tag, "_eof"}, 32'(rd_eof), 32'd1);
        check({tag, "_end_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_end_data"}, 32'(rd_data), 32'd0);
        check({tag, "_end_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Basic write, read stall, ignored inputs in DRAIN and END.
        do_reset("t1");
        foreach (codes1[i]) write_code(codes1[i]);
        send_eof();
        check("t1_count", 32'(count), 32'd11);
        check("t1_first_valid", 32'(rd_valid), 32'd1);
        rd_cs = 1'b1;
        tick();
        rd_cs = 1'b0;
        check("t1_stall1_data", 32'(rd_data), 32'd66);
        check("t1_stall1_valid", 32'(rd_valid), 32'd1);
        in_valid = 1'b1;
        in_data  = DW'(999);
        tick();
        in_valid = 1'b0;
        check("t1_stall2_data", 32'(rd_data), 32'd66);
        check("t1_stall2_valid", 32'(rd_valid), 32'd1);
        tick();
        check("t1_drain_count", 32'(count), 32'd11);
        check("t1_drain_ovf", 32'(overflow), 32'd0);
        rd_cs = 1'b1;
        tick();
        replay_all(9, "t1");
        in_valid = 1'b1;
        in_data  = DW'(5);
        tick();
        in_valid = 1'b0;
        check("t1_end_count", 32'(count), 32'd11);
        check("t1_end_ovf", 32'(overflow), 32'd0);
        check("t1_end_eof", 32'(rd_eof), 32'd1);

        // Full and overflow: 130 writes, only 0..127 kept.
        do_reset("t2");
        for (int i = 0; i < 130; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            if (i < 128) exp_q.push_back(DW'(i));
            tick();
            if (i == 127) begin
                check("t2_ready_full", 32'(in_ready), 32'd0);
                check("t2_ovf_at_full", 32'(overflow), 32'd0);
            end
        end
        in_valid = 1'b0;
        check("t2_count", 32'(count), 32'd128);
        check("t2_ovf", 32'(overflow), 32'd1);
        send_eof();
        replay_all(128, "t2");
        check("t2_ovf_sticky", 32'(overflow), 32'd1);

        // Zero-length file.
        do_reset("t3");
        rd_cs  = 1'b1;
        in_eof = 1'b1;
        tick();
        in_eof = 1'b0;
        check("t3_drain_valid", 32'(rd_valid), 32'd0);
        check("t3_drain_eof", 32'(rd_eof), 32'd0);
        tick();
        check("t3_eof", 32'(rd_eof), 32'd1);
        check("t3_end_valid", 32'(rd_valid), 32'd0);
        rd_cs = 1'b0;

        // Code and eof in the same cycle.
        do_reset("t4");
        in_valid = 1'b1;
        in_data  = DW'(300);
        in_eof   = 1'b1;
        exp_q.push_back(DW'(300));
        tick();
        in_valid = 1'b0;
        in_eof   = 1'b0;
        check("t4_count", 32'(count), 32'd1);
        replay_all(1, "t4");

        // Asynchronous reset mid-drain, then a fresh 3-code file.
        do_reset("t5");
        for (int i = 10; i < 18; i++) write_code(i);
        send_eof();
        rd_cs = 1'b1;
        repeat (5) tick();
        rd_cs = 1'b0;
        check("t5_after5_data", 32'(rd_data), 32'd15);
        do_reset("t5mid");
        write_code(500);
        write_code(501);
        write_code(502);
        send_eof();
        check("t5_new_count", 32'(count), 32'd3);
        replay_all(3, "t5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
